// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: turns line-wide cache reads/writes into 4-beat pmem bursts.
// Optional watchdog (sticky err on a stalled burst) enabled by CACHELINE_BURST_ADAPTOR_WATCHDOG_EN.
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_read,
  input  logic                   line_write,
  input  logic [ADDR_WIDTH-1:0]  line_addr,
  input  logic [LINE_WIDTH-1:0]  line_wdata,
  output logic [LINE_WIDTH-1:0]  line_rdata,
  output logic                   line_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [ADDR_WIDTH-1:0]  pmem_addr,
  output logic [BURST_WIDTH-1:0] pmem_wdata,
  input  logic [BURST_WIDTH-1:0] pmem_rdata,
  input  logic                   pmem_resp,
  output logic                   err
);
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW    = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [LINE_WIDTH-1:0] lbuf;
  logic last;
  assign last = pmem_resp && cnt == CW'(BEATS - 1);
  assign pmem_wdata = lbuf[cnt*BURST_WIDTH +: BURST_WIDTH];
`ifdef CACHELINE_BURST_ADAPTOR_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;
  logic timeout;
  assign timeout = !pmem_resp && wd == WW'(TIMEOUT - 1);
`else
  assign err = 1'b0;
`endif
  // lbuf holds the write line, and doubles as the read assembly buffer so line_rdata only changes at DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lbuf       <= '0;
      line_rdata <= '0;
      line_resp  <= 1'b0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
`ifdef CACHELINE_BURST_ADAPTOR_WATCHDOG_EN
      wd         <= '0;
      err        <= 1'b0;
`endif
    end else begin
      line_resp <= 1'b0;
      case (state)
        IDLE: if (line_read || line_write) begin
          state      <= line_read ? READ : WRITE;
          pmem_read  <= line_read;
          pmem_write <= !line_read;
          pmem_addr  <= line_addr & ~ADDR_WIDTH'(LINE_WIDTH/8 - 1);
          lbuf       <= line_wdata;
          cnt        <= '0;
`ifdef CACHELINE_BURST_ADAPTOR_WATCHDOG_EN
          wd         <= '0;
`endif
        end
        READ, WRITE: begin
`ifdef CACHELINE_BURST_ADAPTOR_WATCHDOG_EN
          wd <= pmem_resp ? '0 : wd + 1'b1;
          if (timeout) begin
            state      <= IDLE;
            err        <= 1'b1;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end else
`endif
          if (pmem_resp) begin
            cnt <= cnt + 1'b1;
            if (state == READ) lbuf[cnt*BURST_WIDTH +: BURST_WIDTH] <= pmem_rdata;
            if (last) begin
              state      <= DONE;
              line_resp  <= 1'b1;
              pmem_read  <= 1'b0;
              pmem_write <= 1'b0;
              if (state == READ) line_rdata <= {pmem_rdata, lbuf[LINE_WIDTH-BURST_WIDTH-1:0]};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb_cacheline_burst_adaptor: directed bursts with a scoreboard of expected lines, beats and addresses.
module tb_cacheline_burst_adaptor;
  localparam int LW = 256, BW = 64, AW = 32;
  logic clk = 0, rst = 0;
  logic line_read = 0, line_write = 0, line_resp, pmem_read, pmem_write, pmem_resp = 0, err;
  logic [AW-1:0] line_addr = '0, pmem_addr;
  logic [LW-1:0] line_wdata = '0, line_rdata;
  logic [BW-1:0] pmem_wdata, pmem_rdata = '0;
  int tests = 0, fails = 0;
  logic [LW-1:0] exp_q[$];
  logic [BW-1:0] beat_q[$];
  logic [AW-1:0] addr_q[$];

  cacheline_burst_adaptor #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .line_read(line_read), .line_write(line_write),
    .line_addr(line_addr), .line_wdata(line_wdata), .line_rdata(line_rdata),
    .line_resp(line_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction; the bench acts as memory, feeding read beats or checking write beats.
  task automatic xfer(input bit wr, input bit both, input logic [AW-1:0] addr,
                      input logic [LW-1:0] line, input int gap);
    line_read  = !wr || both;
    line_write = wr || both;
    line_addr  = addr;
    line_wdata = line;
    addr_q.push_back({addr[AW-1:5], 5'b0});
    for (int k = 0; k < 4; k++) beat_q.push_back(line[k*BW +: BW]);
    if (!wr) exp_q.push_back(line);
    tick;
    line_read  = 0;
    line_write = 0;
    line_addr  = '1;
    line_wdata = '1;
    chk("pmem_addr", pmem_addr, addr_q.pop_front());
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        chk("req_gap", {pmem_write, pmem_read}, wr ? 2'b10 : 2'b01);
        tick;
      end
      chk("req_beat", {pmem_write, pmem_read}, wr ? 2'b10 : 2'b01);
      if (wr) chk("pmem_wdata", pmem_wdata, beat_q.pop_front());
      else pmem_rdata = beat_q.pop_front();
      pmem_resp = 1;
      tick;
      pmem_resp  = 0;
      pmem_rdata = '0;
      if (k < 3) chk("resp_early", line_resp, 0);
    end
    chk("line_resp", line_resp, 1);
    chk("done_req", {pmem_write, pmem_read}, 2'b00);
    if (!wr) chk("line_rdata", line_rdata, exp_q.pop_front());
    tick;
    chk("resp_pulse", line_resp, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_rdata", line_rdata, 0);
    chk("rst_ctrl", {line_resp, pmem_read, pmem_write, err}, 0);
    chk("rst_addr", pmem_addr, 0);
    chk("rst_wdata", pmem_wdata, 0);
    #10 rst = 1;
    tick;
    // pmem_resp while idle must not start or complete anything
    pmem_resp = 1;
    tick;
    tick;
    pmem_resp = 0;
    chk("idle_resp", {line_resp, pmem_read, pmem_write}, 0);
    xfer(0, 0, 32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0);
    xfer(1, 0, 32'h0000_8000, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 2);
    xfer(0, 1, 32'h0000_0040, {64'h0404, 64'h0303, 64'h0202, 64'h0101}, 1);
    xfer(0, 0, 32'h0000_0100, {64'hA4, 64'hA3, 64'hA2, 64'hA1}, 0);
    xfer(1, 0, 32'h0000_0200, {64'hB4, 64'hB3, 64'hB2, 64'hB1}, 0);
    // reset after beat 1 of a read
    line_read = 1;
    line_addr = 32'h0000_0500;
    tick;
    line_read  = 0;
    pmem_rdata = 64'hDEAD_0000;
    pmem_resp  = 1;
    tick;
    pmem_rdata = 64'hDEAD_0001;
    tick;
    pmem_resp = 0;
    #2 rst = 0;
    #1;
    chk("mid_rst_ctrl", {line_resp, pmem_read, pmem_write}, 0);
    chk("mid_rst_addr", pmem_addr, 0);
    chk("mid_rst_rdata", line_rdata, 0);
    chk("mid_rst_wdata", pmem_wdata, 0);
    #1 rst = 1;
    tick;
    chk("mid_rst_noresp", line_resp, 0);
    xfer(0, 0, 32'h0000_0300, {64'hC4, 64'hC3, 64'hC2, 64'hC1}, 1);
`ifdef CACHELINE_BURST_ADAPTOR_WATCHDOG_EN
    line_read = 1;
    line_addr = 32'h0000_0700;
    tick;
    line_read = 0;
    for (int i = 0; i < 7; i++) begin
      chk("wd_pending", {err, line_resp, pmem_read}, 3'b001);
      tick;
    end
    chk("wd_last", {err, pmem_read}, 2'b01);
    tick;
    chk("wd_err", err, 1);
    chk("wd_idle", {line_resp, pmem_read, pmem_write}, 0);
    tick;
    tick;
    chk("wd_sticky", {err, line_resp}, 2'b10);
`else
    chk("err_off", err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Converts full cache-line requests from the last-level cache into 4-beat bursts on the physical memory port (pmem_*) at the mp4 top level.
- Sits directly between the cache hierarchy's line-wide memory interface and the burst memory model driven by the testbench.
- Handles one outstanding transaction at a time.
- Assembles read beats into a line and slices a write line into beats.

Parameters:
- LINE_WIDTH, 256, cache-line width in bits.
- BURST_WIDTH, 64, width of one burst beat in bits. LINE_WIDTH/BURST_WIDTH = BEATS = 4.
- ADDR_WIDTH, 32, address width.
- TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- line_read  input  1  cache requests a line read.
- line_write  input  1  cache requests a line write.
- line_addr  input  ADDR_WIDTH  line request address.
- line_wdata  input  LINE_WIDTH  line to write.
- line_rdata  output  LINE_WIDTH  assembled read line.
- line_resp  output  1  one-cycle completion pulse.
- pmem_read  output  1  burst read request.
- pmem_write  output  1  burst write request.
- pmem_addr  output  ADDR_WIDTH  line-aligned burst address.
- pmem_wdata  output  BURST_WIDTH  current write beat.
- pmem_rdata  input  BURST_WIDTH  current read beat.
- pmem_resp  input  1  beat-valid/accept strobe from memory.
- err  output  1  watchdog error flag (0 when the feature is compiled out).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat counter=0.
  - All outputs are 0, including line_rdata, pmem_addr, pmem_wdata and err.
- States:
  - IDLE -> READ if line_read=1.
  - IDLE -> WRITE if line_write=1 and line_read=0. Read wins if both are asserted.
  - READ/WRITE -> DONE on the pmem_resp that completes beat 3.
  - DONE -> IDLE unconditionally after one cycle.
- Leaving IDLE:
  - Latch pmem_addr = line_addr with bits [4:0] cleared.
  - Latch line_wdata into an internal buffer.
  - Clear the beat counter.
- READ:
  - pmem_read=1 from the first cycle in READ until the cycle carrying beat 3, inclusive.
  - On each cycle with pmem_resp=1, store pmem_rdata into line buffer bits [64*k+63:64*k], k = counter, then increment the counter.
  - Beat 0 occupies the least-significant bits.
  - Beats are accepted with any number of idle cycles between them.
- WRITE:
  - pmem_write=1 for the same span as READ.
  - pmem_wdata = beat k of the latched line, combinationally from the counter.
  - Each pmem_resp advances k; beat 0 is presented in the first WRITE cycle.
- DONE:
  - line_resp=1 for exactly one cycle; pmem_read=pmem_write=0.
  - line_rdata is valid from this cycle and holds until the next read's DONE.
  - line_read and line_write are ignored in DONE.
  - The cache must drop its request in the cycle after line_resp; the earliest new request is accepted in the IDLE cycle that follows.
- Latency: read or write completes in 1 + 4 + idle-gap cycles. line_resp rises in the cycle after the beat-3 edge.
- Counter: 2 bits, wraps 3->0 on the final beat.
- Changes to line_addr or line_wdata mid-transaction have no effect.
- pmem_resp while in IDLE or DONE is ignored.
- Reset mid-burst returns to IDLE immediately with outputs cleared and no line_resp.

Optional Feature:
- Macro CACHELINE_BURST_ADAPTOR_WATCHDOG_EN.
- Defined:
  - A counter counts consecutive READ/WRITE cycles without pmem_resp.
  - When it reaches TIMEOUT, err is set sticky, the state is forced to IDLE and no line_resp is issued.
  - err clears only on reset.
- Undefined: no counter exists, err is tied 0, and the block waits indefinitely.

Test Plan:
- Read 0x0000_1234; pmem_resp on 4 consecutive cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> pmem_addr=0x0000_1220; line_rdata={0x44..44,0x33..33,0x22..22,0x11..11}; line_resp a single pulse 1 cycle after the last beat.
- Write line 0xDDDD..._CCCC..._BBBB..._AAAA... to 0x0000_8000, pmem_resp with 2-cycle gaps -> pmem_wdata sequence AAAA, BBBB, CCCC, DDDD; pmem_write held through beat 3 and deasserted in DONE; exactly 4 beats.
- line_read=line_write=1 at 0x40 -> read burst only; pmem_write never asserted.
- Back-to-back: read 0x100 then write 0x200 issued one cycle after line_resp -> second pmem_addr=0x200; no beat carried over; counter restarted at 0.
- rst=0 after beat 1 of a read, then a fresh read of 0x300 -> outputs 0 asynchronously; new read returns all 4 new beats with no stale data.
- Watchdog defined with TIMEOUT=8, no pmem_resp -> err=1 after 8 cycles; state IDLE; line_resp never pulses.
